// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder and its byte FIFO.
package uart_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with an explicit occupancy counter; DEPTH must be a power of two.
// The head entry is presented combinationally on o_rdata; pushes when full and pops when empty are dropped.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = (AW)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && (r_level != LVL_FULL);
  assign w_pop  = i_pop  && (r_level != '0);

  // NOTE: storage is not reset; pointers and level alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus issue FSM feeding a UART transmitter over TXDATA/TXSTART/TXBUSY/TXDONE.
// Define UART_TX_STATS_EN to add the SENTCNT/DROPCNT statistics counters.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [BYTE_W-1:0]         WDATA,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [$clog2(DEPTH):0]    LEVEL,
  output logic                      EMPTY,
  output logic [BYTE_W-1:0]         TXDATA,
  output logic                      TXSTART,
  input  logic                      TXBUSY,
  input  logic                      TXDONE,
  output logic                      IDLE
`ifdef UART_TX_STATS_EN
  ,
  output logic [15:0]               SENTCNT,
  output logic [15:0]               DROPCNT
`endif
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  tx_state_t         r_state;
  tx_state_t         w_next_state;
  logic [BYTE_W-1:0] r_txdata;
  logic [BYTE_W-1:0] w_head;
  logic [AW:0]       w_level;
  logic              w_wready;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_txstart;

  assign w_wready = (w_level != LVL_FULL);
  assign w_empty  = (w_level == '0);
  assign w_push   = WVALID && w_wready;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_push  (w_push),
    .i_wdata (WDATA),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_level (w_level)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty && !TXBUSY) w_next_state = S_START;
      S_START: w_next_state = S_WAIT;
      S_WAIT:  if (TXDONE) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop     = 1'b0;
    w_txstart = 1'b0;
    case (r_state)
      S_IDLE:  w_pop     = !w_empty && !TXBUSY;
      S_START: w_txstart = 1'b1;
      default: ;
    endcase
  end

  // TXDATA only moves on a pop, so it holds steady for the whole UART transfer.
  always_ff @(posedge CLK) begin
    if (!RESET)     r_txdata <= '0;
    else if (w_pop) r_txdata <= w_head;
  end

`ifdef UART_TX_STATS_EN
  logic [15:0] r_sent_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_sent_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if ((r_state == S_WAIT) && TXDONE) r_sent_cnt <= r_sent_cnt + 16'd1;
      if (WVALID && !w_wready)           r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign SENTCNT = r_sent_cnt;
  assign DROPCNT = r_drop_cnt;
`endif

  assign WREADY  = w_wready;
  assign LEVEL   = w_level;
  assign EMPTY   = w_empty;
  assign TXDATA  = r_txdata;
  assign TXSTART = w_txstart;
  assign IDLE    = (r_state == S_IDLE) && w_empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder with a simple in-line UART response model.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] WDATA;
  logic       WVALID;
  logic       WREADY;
  logic [4:0] LEVEL;
  logic       EMPTY;
  logic [7:0] TXDATA;
  logic       TXSTART;
  logic       TXBUSY;
  logic       TXDONE;
  logic       IDLE;
`ifdef UART_TX_STATS_EN
  logic [15:0] SENTCNT;
  logic [15:0] DROPCNT;
`endif

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .WDATA   (WDATA),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .LEVEL   (LEVEL),
    .EMPTY   (EMPTY),
    .TXDATA  (TXDATA),
    .TXSTART (TXSTART),
    .TXBUSY  (TXBUSY),
    .TXDONE  (TXDONE),
    .IDLE    (IDLE)
`ifdef UART_TX_STATS_EN
    ,
    .SENTCNT (SENTCNT),
    .DROPCNT (DROPCNT)
`endif
  );

  always #5 CLK = ~CLK;

  int         vectors     = 0;
  int         miscompares = 0;
  int         tick_no     = 0;
  int         start_count = 0;
  int         last_done   = -1;
  int         gap_err     = 0;
  int         done_cnt    = 0;
  int         peak        = 0;
  int         s0          = 0;
  bit         auto_en     = 1'b0;
  bit         saw         = 1'b0;
  logic [7:0] sent_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    tick_no++;
    if (int'(LEVEL) > peak) peak = int'(LEVEL);
    if (auto_en) begin
      TXDONE = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          TXDONE    = 1'b1;
          last_done = tick_no;
        end
      end
    end
    if (TXSTART === 1'b1) begin
      start_count++;
      if (auto_en) begin
        sent_q.push_back(TXDATA);
        done_cnt = 20;
        if (last_done >= 0 && (tick_no - last_done) != 2) gap_err++;
      end
    end
  endtask

  task automatic push(input logic [7:0] d);
    bit ok = 1'b0;
    WDATA  = d;
    WVALID = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      ok = (WREADY === 1'b1);
      tick();
    end
    WVALID = 1'b0;
    check("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain(input int n);
    bit done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      tick();
      done = (sent_q.size() == n) && (IDLE === 1'b1);
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    RESET  = 1'b0;
    WVALID = 1'b1;
    WDATA  = 8'hFF;
    TXBUSY = 1'b0;
    TXDONE = 1'b0;

    // Reset held with a producer offering data
    repeat (3) tick();
    check("rst_level",   32'(LEVEL),   32'd0);
    check("rst_wready",  32'(WREADY),  32'd1);
    check("rst_txstart", 32'(TXSTART), 32'd0);
    check("rst_txdata",  32'(TXDATA),  32'h00);
    check("rst_empty",   32'(EMPTY),   32'd1);
    check("rst_idle",    32'(IDLE),    32'd1);
    WVALID = 1'b0;
    RESET  = 1'b1;
    tick();
    check("rst_no_push", 32'(LEVEL), 32'd0);

    // Single byte latency
    start_count = 0;
    WDATA  = 8'hA5;
    WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    check("single_level1",  32'(LEVEL),   32'd1);
    tick();
    check("single_txdata",  32'(TXDATA),  32'hA5);
    check("single_txstart", 32'(TXSTART), 32'd1);
    check("single_level0",  32'(LEVEL),   32'd0);
    tick();
    check("single_pulse_w", 32'(TXSTART), 32'd0);
    repeat (5) tick();
    check("single_no_rest", 32'(start_count), 32'd1);
    TXDONE = 1'b1;
    tick();
    TXDONE = 1'b0;
    check("single_idle", 32'(IDLE), 32'd1);
    tick();
    check("single_one_start", 32'(start_count), 32'd1);

    // Burst of 16 with UART model answering 20 cycles after each start
    sent_q.delete();
    peak = 0; gap_err = 0; last_done = -1; done_cnt = 0;
    auto_en = 1'b1;
    for (int k = 1; k <= 16; k++) push(8'(k));
    wait_drain(16);
    for (int i = 0; i < 16 && i < sent_q.size(); i++)
      check("burst_byte", 32'(sent_q[i]), 32'(i + 1));
    check("burst_peak", 32'((peak == 15) || (peak == 16)), 32'd1);
    check("burst_gap",  32'(gap_err), 32'd0);
    auto_en = 1'b0;
    TXDONE  = 1'b0;

    // Fill to full with the UART stalled, then release
    for (int k = 0; k < 17; k++) push(8'h20 + 8'(k));
    check("full_txdata", 32'(TXDATA), 32'h20);
    check("full_level",  32'(LEVEL),  32'd16);
    check("full_wready", 32'(WREADY), 32'd0);
    check("full_empty",  32'(EMPTY),  32'd0);
    WDATA  = 8'h31;
    WVALID = 1'b1;
    repeat (3) tick();
    check("full_hold_level", 32'(LEVEL), 32'd16);
    TXDONE = 1'b1;
    tick();
    TXDONE = 1'b0;
    check("full_done_wready", 32'(WREADY), 32'd0);
    sent_q.delete();
    last_done = -1; done_cnt = 0; gap_err = 0;
    auto_en = 1'b1;
    tick();
    check("full_pop_wready", 32'(WREADY), 32'd1);
    check("full_pop_level",  32'(LEVEL),  32'd15);
    check("full_pop_txdata", 32'(TXDATA), 32'h21);
    tick();
    WVALID = 1'b0;
    check("full_refill", 32'(LEVEL), 32'd16);
    wait_drain(17);
    for (int i = 0; i < 17 && i < sent_q.size(); i++)
      check("full_byte", 32'(sent_q[i]), 32'h21 + 32'(i));
    check("full_gap", 32'(gap_err), 32'd0);
`ifdef UART_TX_STATS_EN
    check("stats_drop", 32'(DROPCNT), 32'd5);
    check("stats_sent", 32'(SENTCNT), 32'd35);
`endif
    auto_en = 1'b0;
    TXDONE  = 1'b0;

    // TXBUSY hold-off in idle
    TXBUSY = 1'b1;
    push(8'h55);
    push(8'h66);
    s0 = start_count;
    repeat (4) tick();
    check("busy_no_start", 32'(start_count), 32'(s0));
    check("busy_level",    32'(LEVEL),       32'd2);
    check("busy_txdata",   32'(TXDATA),      32'h31);
    TXBUSY = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 2 && !saw; i++) begin
      tick();
      saw = (TXSTART === 1'b1);
    end
    check("busy_release_start", 32'(saw), 32'd1);
    check("busy_release_data",  32'(TXDATA), 32'h55);

    // Reset while waiting on the UART with five bytes queued
    for (int k = 0; k < 4; k++) push(8'h70 + 8'(k));
    check("midrst_level_pre", 32'(LEVEL), 32'd5);
    check("midrst_idle_pre",  32'(IDLE),  32'd0);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    check("midrst_level",   32'(LEVEL),   32'd0);
    check("midrst_empty",   32'(EMPTY),   32'd1);
    check("midrst_idle",    32'(IDLE),    32'd1);
    check("midrst_txstart", 32'(TXSTART), 32'd0);
    check("midrst_txdata",  32'(TXDATA),  32'h00);
`ifdef UART_TX_STATS_EN
    check("midrst_sent", 32'(SENTCNT), 32'd0);
    check("midrst_drop", 32'(DROPCNT), 32'd0);
`endif
    s0 = start_count;
    TXDONE = 1'b1;
    tick();
    TXDONE = 1'b0;
    repeat (3) tick();
    check("stray_done_start", 32'(start_count), 32'(s0));
    check("stray_done_idle",  32'(IDLE),        32'd1);
`ifdef UART_TX_STATS_EN
    check("stray_done_sent", 32'(SENTCNT), 32'd0);
`endif

    // After reset the UART may still be busy: issue waits for TXBUSY low
    TXBUSY = 1'b1;
    push(8'h99);
    repeat (3) tick();
    check("postrst_busy_hold", 32'(start_count), 32'(s0));
    TXBUSY = 1'b0;
    tick();
    check("postrst_start",  32'(TXSTART), 32'd1);
    check("postrst_txdata", 32'(TXDATA),  32'h99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Byte FIFO plus issue FSM that sits directly upstream of the UART transmitter. It accepts bytes from a producer via a valid/ready write port and buffers up to DEPTH bytes. It hands them to the UART one at a time over the TXDATA/TXSTART/TXBUSY/TXDONE handshake, so producers never have to poll TXBUSY.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
AW, $clog2(DEPTH), localparam; pointer width; level width is AW+1

Ports:
CLK  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous, active-low reset
WDATA  in  8  byte from producer
WVALID  in  1  producer offers WDATA this cycle
WREADY  out  1  FIFO can accept; high iff level < DEPTH
LEVEL  out  AW+1  current FIFO occupancy, 0..DEPTH
EMPTY  out  1  high iff LEVEL == 0
TXDATA  out  8  byte to UART; registered, stable from TXSTART until TXDONE
TXSTART  out  1  one-cycle pulse requesting UART transmission
TXBUSY  in  1  UART transmitter busy
TXDONE  in  1  UART one-cycle pulse, byte fully sent
IDLE  out  1  high iff FSM in S_IDLE and FIFO empty

Behaviour:
- Reset (RESET == 0 at a rising edge): rd/wr pointers and level = 0, FSM = S_IDLE. Outputs: TXDATA = 8'h00, TXSTART = 0, WREADY = 1, LEVEL = 0, EMPTY = 1, IDLE = 1.
- Write: push occurs on an edge where WVALID && WREADY. Writes while full are ignored; the producer must hold WVALID.
- WREADY, LEVEL, EMPTY are combinational from registered level. No same-cycle pass-through when full: a pop frees a slot for the next cycle.
- Simultaneous push and pop: level unchanged; both pointers advance. Pointers wrap modulo DEPTH. Level is tracked explicitly to distinguish full from empty.
- FSM states:
  - S_IDLE: if !EMPTY && !TXBUSY -> pop head into TXDATA, go to S_START.
  - S_START: TXSTART = 1 for exactly this cycle -> S_WAIT.
  - S_WAIT: stay until TXDONE == 1, then -> S_IDLE. TXBUSY is ignored in this state.
- Latency: a byte pushed into an empty FIFO with TXBUSY low at edge n appears on TXDATA after edge n+1. TXSTART is high during the cycle between edges n+1 and n+2.
- Back-to-back throughput: after a TXDONE pulse, the next TXSTART comes 2 cycles later (S_IDLE pop, then S_START).
- TXDONE seen outside S_WAIT: ignored.
- TXBUSY high in S_IDLE (e.g. UART still busy after a feeder reset): issue is held off; no pop occurs.
- Reset mid-operation: FIFO contents are discarded and FSM returns to S_IDLE. The UART finishes its current byte independently. The feeder waits for TXBUSY low before its next start.
- TXDATA is changed only on a pop.

Optional Feature:
UART_TX_STATS_EN
- Defined: adds output ports SENTCNT[15:0] and DROPCNT[15:0].
  - SENTCNT increments on each TXDONE received in S_WAIT.
  - DROPCNT increments each cycle with WVALID && !WREADY.
  - Both counters wrap 16'hFFFF -> 0 and reset to 0.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (S_IDLE, S_START, S_WAIT; 2-bit encoding)
  - byte width constant BYTE_W = 8
  - default DEPTH constant
- Sub-module sync_fifo (parameters DEPTH, WIDTH) contains storage, pointers and level. uart_tx_feeder instantiates it and adds the FSM and the optional stats.

Test Plan:
- Reset: hold RESET = 0 for 3 cycles with WVALID = 1 -> LEVEL = 0, WREADY = 1, TXSTART = 0, TXDATA = 8'h00, no push recorded.
- Single byte: push 8'hA5 into empty FIFO, TXBUSY = 0 -> TXDATA = 8'hA5 and TXSTART pulse 1 cycle wide 2 edges after the push. No further TXSTART until TXDONE is pulsed. LEVEL returns to 0.
- Burst: push 8'h01..8'h10 (16 bytes) back-to-back, with a UART model giving TXDONE 20 cycles after each TXSTART -> bytes emitted in order 01..10. Each TXSTART comes 2 cycles after the previous TXDONE. Peak LEVEL is 15 or 16.
- Full: block TXDONE, push 18 bytes -> WREADY drops when LEVEL = 16 and the last bytes are held by the producer. Releasing TXDONE -> WREADY high the cycle after the pop. No byte is lost or duplicated.
- Busy hold-off: TXBUSY = 1 forced with FIFO non-empty -> no TXSTART and LEVEL stays constant. Dropping TXBUSY -> TXSTART within 2 cycles.
- Reset mid-burst: RESET = 0 while in S_WAIT with LEVEL = 5 -> LEVEL = 0 and FSM idle; a stray TXDONE after reset is ignored. With UART_TX_STATS_EN, SENTCNT/DROPCNT = 0.
